// File: rtl/regfile_dump.sv
// regfile_dump: walks register addresses 0..DIRECCIONES-1 over one read port
// of the register file, samples each word and streams it out MSB byte first
// on a valid/ready byte interface.
//
// Optional framing, enabled by defining REGFILE_DUMP_FRAME_EN: a 0xA5 header
// byte precedes the data and an XOR checksum of all data bytes follows it.
// The header cycle also samples register 0, so framing costs only one extra
// cycle at full rate.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for Start
// HEADER    | (framing only) offer 0xA5, capture register 0 on transfer
// LOAD      | ARead = address counter, capture DRead into shift register
// SEND      | offer shift register top byte until all bytes transferred
// CHECKSUM  | (framing only) offer XOR of all data bytes
// DONE      | one-cycle Done pulse, back to IDLE
module regfile_dump #(
    parameter int S_AD        = 5,
    parameter int S_DATA      = 32,
    parameter int DIRECCIONES = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              Start,
    output logic [S_AD-1:0]   ARead,
    input  logic [S_DATA-1:0] DRead,
    output logic [7:0]        ByteOut,
    output logic              ByteValid,
    input  logic              ByteReady,
    output logic              Busy,
    output logic              Done
);

    localparam int NBYTES = S_DATA / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [BCW-1:0]  LAST_BYTE = BCW'(NBYTES - 1);
    localparam logic [S_AD-1:0] LAST_ADDR = S_AD'(DIRECCIONES - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_SEND     = 3'd2;
    localparam logic [2:0] ST_DONE     = 3'd3;
`ifdef REGFILE_DUMP_FRAME_EN
    localparam logic [2:0] ST_HEADER   = 3'd4;
    localparam logic [2:0] ST_CHECKSUM = 3'd5;
`endif

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [S_AD-1:0]   addr_cnt;
    logic [BCW-1:0]    byte_cnt;
    logic [S_DATA-1:0] shift_q;
    logic              xfer;
    logic              last_byte;
    logic              last_addr;
`ifdef REGFILE_DUMP_FRAME_EN
    logic [7:0]        csum;
`endif

    // ARead is the address counter itself: it only moves on edges into LOAD
    // (or HEADER), so it naturally holds its value everywhere else.
    assign ARead     = addr_cnt;
    assign Done      = (state == ST_DONE);
    assign last_byte = (byte_cnt == LAST_BYTE);
    assign last_addr = (addr_cnt == LAST_ADDR);
    assign xfer      = ByteValid & ByteReady;

    // Output decode from the current state
    always_comb begin
        ByteValid = 1'b0;
        Busy      = 1'b0;
        ByteOut   = shift_q[S_DATA-1 -: 8];
        case (state)
            ST_LOAD: begin
                Busy = 1'b1;
            end
            ST_SEND: begin
                Busy      = 1'b1;
                ByteValid = 1'b1;
            end
`ifdef REGFILE_DUMP_FRAME_EN
            ST_HEADER: begin
                Busy      = 1'b1;
                ByteValid = 1'b1;
                ByteOut   = 8'hA5;
            end
            ST_CHECKSUM: begin
                Busy      = 1'b1;
                ByteValid = 1'b1;
                ByteOut   = csum;
            end
`endif
            default: ;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
`ifdef REGFILE_DUMP_FRAME_EN
                if (Start) state_nxt = ST_HEADER;
`else
                if (Start) state_nxt = ST_LOAD;
`endif
            end
            ST_LOAD: begin
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (xfer && last_byte) begin
                    if (last_addr) begin
`ifdef REGFILE_DUMP_FRAME_EN
                        state_nxt = ST_CHECKSUM;
`else
                        state_nxt = ST_DONE;
`endif
                    end else begin
                        state_nxt = ST_LOAD;
                    end
                end
            end
`ifdef REGFILE_DUMP_FRAME_EN
            ST_HEADER: begin
                if (xfer) state_nxt = ST_SEND;
            end
            ST_CHECKSUM: begin
                if (xfer) state_nxt = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Address counter, byte counter, shift register and checksum
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr_cnt <= '0;
            byte_cnt <= '0;
            shift_q  <= '0;
`ifdef REGFILE_DUMP_FRAME_EN
            csum     <= 8'h00;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        addr_cnt <= '0;
`ifdef REGFILE_DUMP_FRAME_EN
                        csum     <= 8'h00;
`endif
                    end
                end
                ST_LOAD: begin
                    shift_q  <= DRead;
                    byte_cnt <= '0;
                end
`ifdef REGFILE_DUMP_FRAME_EN
                // Register 0 is already addressed, so sample it here and
                // skip its LOAD cycle.
                ST_HEADER: begin
                    if (xfer) begin
                        shift_q  <= DRead;
                        byte_cnt <= '0;
                    end
                end
`endif
                ST_SEND: begin
                    if (xfer) begin
                        shift_q  <= shift_q << 8;
                        byte_cnt <= byte_cnt + BCW'(1);
`ifdef REGFILE_DUMP_FRAME_EN
                        csum     <= csum ^ ByteOut;
`endif
                        if (last_byte && !last_addr) addr_cnt <= addr_cnt + S_AD'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a behavioural register file, an expected-byte
// queue filled when a dump is launched and drained by a byte monitor, plus
// a second small instance (4 registers) for the terminal-count case.
module tb_regfile_dump;

    localparam int NREG = 32;
`ifdef REGFILE_DUMP_FRAME_EN
    localparam int FRAME = 1;
`else
    localparam int FRAME = 0;
`endif
    localparam int STREAM_LEN  = NREG * 4 + 2 * FRAME;
    localparam int DONE_LAT    = 161 + FRAME;
    localparam int STREAM_LEN4 = 16 + 2 * FRAME;
    localparam int DONE_LAT4   = 21 + FRAME;

    logic        CLK;
    logic        RST_N;
    logic        Start;
    logic [4:0]  ARead;
    logic [31:0] DRead;
    logic [7:0]  ByteOut;
    logic        ByteValid;
    logic        ByteReady;
    logic        Busy;
    logic        Done;

    logic        Start4;
    logic [4:0]  ARead4;
    logic [31:0] DRead4;
    logic [7:0]  ByteOut4;
    logic        ByteValid4;
    logic        ByteReady4;
    logic        Busy4;
    logic        Done4;

    logic [31:0] regs [NREG];

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          n_xfer = 0;
    bit          mon_en = 0;
    logic [7:0]  exp_q [$];

    assign DRead  = regs[ARead];
    assign DRead4 = regs[ARead4];

    regfile_dump dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .Start     (Start),
        .ARead     (ARead),
        .DRead     (DRead),
        .ByteOut   (ByteOut),
        .ByteValid (ByteValid),
        .ByteReady (ByteReady),
        .Busy      (Busy),
        .Done      (Done)
    );

    regfile_dump #(.S_AD(5), .S_DATA(32), .DIRECCIONES(4)) dut4 (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .Start     (Start4),
        .ARead     (ARead4),
        .DRead     (DRead4),
        .ByteOut   (ByteOut4),
        .ByteValid (ByteValid4),
        .ByteReady (ByteReady4),
        .Busy      (Busy4),
        .Done      (Done4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Byte monitor: pops the scoreboard on every transfer and checks that a
    // stalled byte stays put until it is accepted.
    initial begin : monitor
        bit         hold_pending;
        logic [7:0] held;
        logic [7:0] e;
        hold_pending = 0;
        held = 8'h00;
        forever begin
            @(negedge CLK);
            if (mon_en && RST_N) begin
                if (hold_pending) begin
                    n_cmp++;
                    if (ByteValid !== 1'b1 || ByteOut !== held) begin
                        n_fail++;
                        $display("FAIL stall_hold: got valid=%b byte=%h want valid=1 byte=%h",
                                 ByteValid, ByteOut, held);
                    end
                end
                hold_pending = ByteValid && !ByteReady;
                held = ByteOut;
                if (ByteValid && ByteReady) begin
                    n_xfer++;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL stream_extra: got byte %h want no byte", ByteOut);
                    end else begin
                        e = exp_q.pop_front();
                        if (ByteOut !== e) begin
                            n_fail++;
                            $display("FAIL stream_byte[%0d]: got %h want %h", n_xfer - 1, ByteOut, e);
                        end
                    end
                end
            end else begin
                hold_pending = 0;
            end
        end
    end

    task automatic push_expected();
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        exp_q.delete();
        if (FRAME != 0) exp_q.push_back(8'hA5);
        for (int k = 0; k < NREG; k++) begin
            for (int j = 3; j >= 0; j--) begin
                b = regs[k][j*8 +: 8];
                exp_q.push_back(b);
                cs = cs ^ b;
            end
        end
        if (FRAME != 0) exp_q.push_back(cs);
        n_xfer = 0;
    endtask

    // Launches one dump (Start sampled at edge 0) and runs cycles 1..budget,
    // recording Done and Busy behaviour. mode 0: ready=1, mode 1: ready
    // toggles 1,0,1,0, mode 2: ready=1 with extra Start pulses.
    task automatic drive_dump(input int mode, input int budget,
                              output int done_cyc, output int done_cnt,
                              output int busy_bad);
        done_cyc = -1;
        done_cnt = 0;
        busy_bad = 0;
        @(posedge CLK); #1;
        Start = 1'b1;
        ByteReady = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            ByteReady = (mode == 1) ? (cyc % 2 == 1) : 1'b1;
            Start = (mode == 2) && (cyc == 5 || cyc == 50 || cyc == 161);
            @(negedge CLK);
            if (Done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if ((done_cyc < 0) == (Busy == 1'b0)) busy_bad++;
            @(posedge CLK); #1;
        end
        Start = 1'b0;
        ByteReady = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (ByteValid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", ByteValid); end
        n_cmp++; if (Busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b want 0", Busy); end
        n_cmp++; if (Done !== 1'b0)      begin n_fail++; $display("FAIL rst_done: got %b want 0", Done); end
        n_cmp++; if (ARead !== 5'd0)     begin n_fail++; $display("FAIL rst_aread: got %0d want 0", ARead); end
        n_cmp++; if (ByteOut !== 8'h00)  begin n_fail++; $display("FAIL rst_byte: got %h want 00", ByteOut); end
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        // Start a dump and abort it in cycle 8 (second register, SEND).
        @(posedge CLK); #1;
        Start = 1'b1;
        ByteReady = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        repeat (7) @(posedge CLK);
        #1;
        n_cmp++; if (ByteValid !== 1'b1) begin n_fail++; $display("FAIL pre_abort_valid: got %b want 1", ByteValid); end
        n_cmp++; if (ARead !== 5'd1)     begin n_fail++; $display("FAIL pre_abort_aread: got %0d want 1", ARead); end
        RST_N = 1'b0;
        #2;
        n_cmp++; if (ByteValid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b want 0", ByteValid); end
        n_cmp++; if (Busy !== 1'b0)      begin n_fail++; $display("FAIL abort_busy: got %b want 0", Busy); end
        n_cmp++; if (Done !== 1'b0)      begin n_fail++; $display("FAIL abort_done: got %b want 0", Done); end
        n_cmp++; if (ARead !== 5'd0)     begin n_fail++; $display("FAIL abort_aread: got %0d want 0", ARead); end
        n_cmp++; if (ByteOut !== 8'h00)  begin n_fail++; $display("FAIL abort_byte: got %h want 00", ByteOut); end
        ByteReady = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
    endtask

    task automatic check_dump(input string tag, input int done_cyc, input int done_cnt,
                              input int busy_bad, input bit check_lat);
        if (check_lat) begin
            n_cmp++;
            if (done_cyc != DONE_LAT) begin
                n_fail++;
                $display("FAIL %s_done_cycle: got %0d want %0d", tag, done_cyc, DONE_LAT);
            end
        end else begin
            n_cmp++;
            if (done_cyc <= 0) begin
                n_fail++;
                $display("FAIL %s_timeout: got done cycle %0d want >0", tag, done_cyc);
            end
        end
        n_cmp++; if (done_cnt != 1)          begin n_fail++; $display("FAIL %s_done_pulses: got %0d want 1", tag, done_cnt); end
        n_cmp++; if (busy_bad != 0)          begin n_fail++; $display("FAIL %s_busy: got %0d bad cycles want 0", tag, busy_bad); end
        n_cmp++; if (n_xfer != STREAM_LEN)   begin n_fail++; $display("FAIL %s_bytes: got %0d want %0d", tag, n_xfer, STREAM_LEN); end
        n_cmp++; if (exp_q.size() != 0)      begin n_fail++; $display("FAIL %s_missing: got %0d left want 0", tag, exp_q.size()); end
    endtask

    task automatic test_full_rate();
        int dc, dn, bb;
        for (int k = 0; k < NREG; k++) regs[k] = 32'h0102_0300 + k;
        push_expected();
        mon_en = 1;
        drive_dump(0, 200, dc, dn, bb);
        mon_en = 0;
        check_dump("full", dc, dn, bb, 1'b1);
    endtask

    task automatic test_backpressure();
        int dc, dn, bb;
        push_expected();
        mon_en = 1;
        drive_dump(1, 400, dc, dn, bb);
        mon_en = 0;
        check_dump("bp", dc, dn, bb, 1'b0);
    endtask

    task automatic test_start_while_busy();
        int dc, dn, bb;
        push_expected();
        mon_en = 1;
        drive_dump(2, 200, dc, dn, bb);
        mon_en = 0;
        check_dump("busy_start", dc, dn, bb, 1'b1);
    endtask

    task automatic test_terminal_count();
        int         seen [$];
        logic [4:0] last;
        int         nb;
        int         dcyc;
        int         nb_at_done;
        int         max_a;
        nb = 0;
        dcyc = -1;
        nb_at_done = -1;
        max_a = 0;
        last = ARead4;
        seen.push_back(int'(ARead4));
        ByteReady4 = 1'b1;
        @(posedge CLK); #1;
        Start4 = 1'b1;
        @(posedge CLK); #1;
        Start4 = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge CLK);
            if (ARead4 != last) begin
                seen.push_back(int'(ARead4));
                last = ARead4;
            end
            if (int'(ARead4) > max_a) max_a = int'(ARead4);
            if (Done4 && dcyc < 0) begin
                dcyc = cyc;
                nb_at_done = nb;
            end
            if (ByteValid4 && ByteReady4) nb++;
            @(posedge CLK); #1;
        end
        n_cmp++; if (dcyc != DONE_LAT4)         begin n_fail++; $display("FAIL tc_done_cycle: got %0d want %0d", dcyc, DONE_LAT4); end
        n_cmp++; if (nb_at_done != STREAM_LEN4) begin n_fail++; $display("FAIL tc_bytes_at_done: got %0d want %0d", nb_at_done, STREAM_LEN4); end
        n_cmp++; if (nb != STREAM_LEN4)         begin n_fail++; $display("FAIL tc_total_bytes: got %0d want %0d", nb, STREAM_LEN4); end
        n_cmp++; if (max_a != 3)                begin n_fail++; $display("FAIL tc_max_aread: got %0d want 3", max_a); end
        n_cmp++; if (Busy4 !== 1'b0)            begin n_fail++; $display("FAIL tc_busy_after: got %b want 0", Busy4); end
        n_cmp++;
        if (seen.size() != 4) begin
            n_fail++;
            $display("FAIL tc_aread_steps: got %0d distinct want 4", seen.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (seen[i] != i) begin
                    n_fail++;
                    $display("FAIL tc_aread[%0d]: got %0d want %0d", i, seen[i], i);
                end
            end
        end
    endtask

`ifdef REGFILE_DUMP_FRAME_EN
    task automatic test_framing();
        int dc, dn, bb;
        for (int k = 0; k < NREG; k++) regs[k] = 32'hFFFF_FFFF;
        push_expected();
        n_cmp++;
        if (exp_q[0] !== 8'hA5 || exp_q[STREAM_LEN-1] !== 8'h00) begin
            n_fail++;
            $display("FAIL frame_model: got %h..%h want a5..00", exp_q[0], exp_q[STREAM_LEN-1]);
        end
        mon_en = 1;
        drive_dump(0, 200, dc, dn, bb);
        mon_en = 0;
        check_dump("frame", dc, dn, bb, 1'b1);
    endtask
`endif

    initial begin
        RST_N      = 1'b0;
        Start      = 1'b0;
        ByteReady  = 1'b0;
        Start4     = 1'b0;
        ByteReady4 = 1'b0;
        for (int k = 0; k < NREG; k++) regs[k] = 32'h0102_0300 + k;
        test_reset();
        test_full_rate();
        test_backpressure();
        test_start_while_busy();
        test_terminal_count();
`ifdef REGFILE_DUMP_FRAME_EN
        test_framing();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
